multicycle_control_fsm: RTL
===========================

// Module: multicycle_control_fsm
// PURPOSE
//  Multi-cycle sequencer for the 32-bit processor datapath: FETCH/DECODE/EXEC/MEM/WB.
//  Decodes the 5-bit opcode and drives per-state datapath strobes and mux selects.
//  Handles the ready handshake of a shared instruction/data memory, with a wait-timeout trap.
//  Sits between the IR opcode field and the PC, register file, ALU and memory port.
// PARAMETERS
//  OPW          5   opcode width
//  MEM_TIMEOUT  15  max wait cycles with mem_req=1 && mem_ready=0; range 1..255
//  TW           8   timeout counter width
// PORTS
//  clock        in   1  single clock; all state changes on its rising edge
//  reset_n      in   1  asynchronous, active-low reset
//  opcode       in   5  IR[31:27]; sampled only in DECODE/EXEC/MEM/WB
//  alu_zero     in   1  ALU result == 0 (valid in EXEC)
//  alu_lt       in   1  signed rs < rt (valid in EXEC)
//  mem_ready    in   1  memory accepted write / read data valid this cycle
//  mem_req      out  1  memory access request, held until mem_ready
//  mem_we       out  1  write qualifier for mem_req
//  iord         out  1  mem address: 0=PC, 1=ALU result
//  ir_write     out  1  load IR from mem read data
//  pc_write     out  1  load PC
//  pc_src       out  2  00=PC+1, 01=branch target, 10=jump target, 11=rs
//  alu_src_b    out  1  0=rt, 1=sign-extended immediate
//  alu_op       out  2  00=add, 01=sub/compare, 10=use funct
//  reg_write    out  1  register-file write enable
//  reg_dst      out  2  00=rd, 01=rt, 10=r31
//  mem_to_reg   out  2  00=ALU, 01=mem data, 10=PC (link)
//  instr_retire out  1  one-cycle pulse in the final cycle of each instruction
//  illegal_op   out  1  sticky: unknown opcode trapped
//  mem_timeout  out  1  sticky: memory wait exceeded MEM_TIMEOUT
//  state_o      out  3  current state, for debug/verification
// BEHAVIOUR
//  - Outputs are combinational from state (+ opcode/flags/mem_ready). Reset: state=IDLE, all outputs 0.
//  - IDLE: all outputs 0; next = FETCH unconditionally (first fetch starts 1 cycle after reset release).
//  - FETCH: mem_req=1, iord=0. On mem_ready: ir_write=1, pc_write=1, pc_src=00 -> DECODE.
//    Else stay in FETCH.
//  - DECODE: 1 cycle, no strobes. Legal opcodes -> EXEC:
//    Rtype 00000, j 00001, bne 00010, jal 00011, jr 00100, addi 00101, blt 00110, sw 00111, lw 01000.
//    Any other opcode -> TRAP and set illegal_op.
//  - EXEC:
//    Rtype: alu_op=10 -> WB.
//    addi: alu_src_b=1, alu_op=00 -> WB.
//    lw/sw: alu_src_b=1, alu_op=00 -> MEM.
//    bne: alu_op=01; pc_write=!alu_zero, pc_src=01. Retire -> FETCH.
//    blt: alu_op=01; pc_write=alu_lt, pc_src=01. Retire -> FETCH.
//    j: pc_write=1, pc_src=10. Retire -> FETCH.
//    jr: pc_write=1, pc_src=11. Retire -> FETCH.
//    jal: pc_write=1, pc_src=10, plus reg_write=1, reg_dst=10, mem_to_reg=10 in the same cycle.
//      The write sees the pre-edge PC (already PC+1). Retire -> FETCH.
//  - MEM: mem_req=1, iord=1, mem_we=(opcode==sw).
//    On mem_ready: sw retires -> FETCH; lw -> WB. Else stay in MEM.
//  - WB: reg_write=1.
//    Rtype: reg_dst=00, mem_to_reg=00.
//    addi: reg_dst=01, mem_to_reg=00.
//    lw: reg_dst=01, mem_to_reg=01.
//    Retire -> FETCH.
//  - Latency, zero-wait memory: jumps/branches 3 cycles; Rtype/addi/sw 4; lw 5.
//    Each memory wait cycle adds 1.
//  - Timeout: counter increments each cycle with mem_req && !mem_ready.
//    Counter clears on mem_ready and on any state change.
//    The cycle it would reach MEM_TIMEOUT: -> TRAP, set mem_timeout, mem_req drops.
//  - TRAP: all strobes 0; held until reset_n. Sticky flags clear only on reset.
//  - mem_ready outside FETCH/MEM is ignored.
//  - Reset mid-instruction: immediate return to IDLE; partially done work is discarded.
//  - reg_write, pc_write and mem_we are never asserted in IDLE, DECODE or TRAP.
// STRUCTURE
//  - cpu_ctrl_pkg: opcode localparams; state encoding (IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4,
//    WB=5, TRAP=7); pc_src, reg_dst, mem_to_reg and alu_op encodings.
//  - Sub-module mem_wait_timer: counter, clear and expiry compare; parameters MEM_TIMEOUT and TW.
//  - Top level: state register plus one combinational output-decode process.
// TESTING
//  1. Reset, then addi (00101) with mem_ready tied 1.
//     -> states 0,1,2,3,5,1; in WB: reg_write=1, reg_dst=01; instr_retire in the WB cycle.
//  2. lw (01000) with mem_ready low for 3 MEM cycles.
//     -> MEM held 4 cycles, mem_we=0, iord=1; WB mem_to_reg=01; total latency 8 cycles.
//  3. bne with alu_zero=0, then bne with alu_zero=1.
//     -> pc_write=1, pc_src=01 in EXEC; then pc_write=0 in EXEC. Both return to FETCH after 3 cycles.
//  4. jal.
//     -> a single EXEC cycle with pc_write=1, pc_src=10, reg_write=1, reg_dst=10, mem_to_reg=10.
//  5. Opcode 11111; separately, mem_ready held 0 in FETCH with MEM_TIMEOUT=15.
//     -> case 1: TRAP after DECODE, illegal_op=1.
//     -> case 2: TRAP after 15 wait cycles, mem_timeout=1; stays in TRAP until reset_n pulse.
//  6. reset_n low during MEM of sw.
//     -> state_o=0 and all outputs 0 asynchronously; FETCH 1 cycle after release; no mem_we afterwards.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle sequencer:
// opcodes, FSM states and datapath mux selects.
package cpu_ctrl_pkg;

   localparam logic [4:0] OP_RTYPE = 5'b00000;
   localparam logic [4:0] OP_J     = 5'b00001;
   localparam logic [4:0] OP_BNE   = 5'b00010;
   localparam logic [4:0] OP_JAL   = 5'b00011;
   localparam logic [4:0] OP_JR    = 5'b00100;
   localparam logic [4:0] OP_ADDI  = 5'b00101;
   localparam logic [4:0] OP_BLT   = 5'b00110;
   localparam logic [4:0] OP_SW    = 5'b00111;
   localparam logic [4:0] OP_LW    = 5'b01000;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_TRAP   = 3'd7
   } state_t;

   localparam logic [1:0] PC_INC = 2'b00;
   localparam logic [1:0] PC_BR  = 2'b01;
   localparam logic [1:0] PC_JMP = 2'b10;
   localparam logic [1:0] PC_RS  = 2'b11;

   localparam logic [1:0] RD_RD  = 2'b00;
   localparam logic [1:0] RD_RT  = 2'b01;
   localparam logic [1:0] RD_R31 = 2'b10;

   localparam logic [1:0] MTR_ALU = 2'b00;
   localparam logic [1:0] MTR_MEM = 2'b01;
   localparam logic [1:0] MTR_PC  = 2'b10;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   // Legal opcodes are exactly the contiguous range 0..8.
   function automatic logic is_legal(input logic [4:0] op);
      return op <= OP_LW;
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive memory wait cycles and flags the
// cycle in which the count would reach MEM_TIMEOUT.
module mem_wait_timer #(
   parameter int MEM_TIMEOUT = 15,
   parameter int TW          = 8
) (
   input  logic clock,
   input  logic reset_n,
   input  logic i_wait,
   input  logic i_ready,
   input  logic i_clr,
   output logic o_expire
);

   localparam logic [TW-1:0] LIMIT = TW'(MEM_TIMEOUT);

   logic [TW-1:0] r_cnt;
   logic [TW-1:0] w_inc;

   assign w_inc    = r_cnt + TW'(1);
   assign o_expire = i_wait && (w_inc == LIMIT);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt <= '0;
      end else if (i_ready || i_clr) begin
         r_cnt <= '0;
      end else if (i_wait) begin
         r_cnt <= w_inc;
      end
   end

endmodule

// File: rtl/multicycle_control_fsm.sv
// FETCH/DECODE/EXEC/MEM/WB sequencer driving datapath
// strobes, with illegal-opcode and memory-timeout traps.
module multicycle_control_fsm
   import cpu_ctrl_pkg::*;
#(
   parameter int OPW         = 5,
   parameter int MEM_TIMEOUT = 15,
   parameter int TW          = 8
) (
   input  logic           clock,
   input  logic           reset_n,
   input  logic [OPW-1:0] opcode,
   input  logic           alu_zero,
   input  logic           alu_lt,
   input  logic           mem_ready,
   output logic           mem_req,
   output logic           mem_we,
   output logic           iord,
   output logic           ir_write,
   output logic           pc_write,
   output logic [1:0]     pc_src,
   output logic           alu_src_b,
   output logic [1:0]     alu_op,
   output logic           reg_write,
   output logic [1:0]     reg_dst,
   output logic [1:0]     mem_to_reg,
   output logic           instr_retire,
   output logic           illegal_op,
   output logic           mem_timeout,
   output logic [2:0]     state_o
);

   state_t r_state;
   state_t w_next;
   logic   r_illegal;
   logic   r_tmo;
   logic   w_set_ill;
   logic   w_set_tmo;
   logic   w_wait;
   logic   w_expire;
   logic   w_clr;

   // Wait qualifier comes from state, not from mem_req, to keep
   // the expiry path free of a combinational loop.
   assign w_wait = ((r_state == S_FETCH) || (r_state == S_MEM))
                   && !mem_ready;
   assign w_clr  = (w_next != r_state);

   mem_wait_timer #(
      .MEM_TIMEOUT (MEM_TIMEOUT),
      .TW          (TW)
   ) u_timer (
      .clock    (clock),
      .reset_n  (reset_n),
      .i_wait   (w_wait),
      .i_ready  (mem_ready),
      .i_clr    (w_clr),
      .o_expire (w_expire)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= S_IDLE;
         r_illegal <= 1'b0;
         r_tmo     <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_illegal <= r_illegal | w_set_ill;
         r_tmo     <= r_tmo | w_set_tmo;
      end
   end

   always_comb begin
      w_next       = r_state;
      w_set_ill    = 1'b0;
      w_set_tmo    = 1'b0;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      iord         = 1'b0;
      ir_write     = 1'b0;
      pc_write     = 1'b0;
      pc_src       = PC_INC;
      alu_src_b    = 1'b0;
      alu_op       = ALU_ADD;
      reg_write    = 1'b0;
      reg_dst      = RD_RD;
      mem_to_reg   = MTR_ALU;
      instr_retire = 1'b0;
      unique case (r_state)
         S_IDLE: w_next = S_FETCH;
         S_FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               w_next   = S_DECODE;
            end else if (w_expire) begin
               w_set_tmo = 1'b1;
               w_next    = S_TRAP;
            end
         end
         S_DECODE: begin
            if (is_legal(opcode)) begin
               w_next = S_EXEC;
            end else begin
               w_set_ill = 1'b1;
               w_next    = S_TRAP;
            end
         end
         S_EXEC: begin
            unique case (opcode)
               OP_RTYPE: begin
                  alu_op = ALU_FUNCT;
                  w_next = S_WB;
               end
               OP_ADDI, OP_LW, OP_SW: begin
                  alu_src_b = 1'b1;
                  w_next    = (opcode == OP_ADDI) ? S_WB : S_MEM;
               end
               OP_BNE: begin
                  alu_op       = ALU_SUB;
                  pc_write     = !alu_zero;
                  pc_src       = PC_BR;
                  instr_retire = 1'b1;
                  w_next       = S_FETCH;
               end
               OP_BLT: begin
                  alu_op       = ALU_SUB;
                  pc_write     = alu_lt;
                  pc_src       = PC_BR;
                  instr_retire = 1'b1;
                  w_next       = S_FETCH;
               end
               OP_J, OP_JR: begin
                  pc_write     = 1'b1;
                  pc_src       = (opcode == OP_J) ? PC_JMP : PC_RS;
                  instr_retire = 1'b1;
                  w_next       = S_FETCH;
               end
               OP_JAL: begin
                  pc_write     = 1'b1;
                  pc_src       = PC_JMP;
                  reg_write    = 1'b1;
                  reg_dst      = RD_R31;
                  mem_to_reg   = MTR_PC;
                  instr_retire = 1'b1;
                  w_next       = S_FETCH;
               end
               default: begin
                  w_set_ill = 1'b1;
                  w_next    = S_TRAP;
               end
            endcase
         end
         S_MEM: begin
            mem_req = 1'b1;
            iord    = 1'b1;
            mem_we  = (opcode == OP_SW);
            if (mem_ready) begin
               instr_retire = (opcode == OP_SW);
               w_next       = (opcode == OP_SW) ? S_FETCH : S_WB;
            end else if (w_expire) begin
               w_set_tmo = 1'b1;
               w_next    = S_TRAP;
            end
         end
         S_WB: begin
            reg_write    = 1'b1;
            instr_retire = 1'b1;
            w_next       = S_FETCH;
            unique case (opcode)
               OP_ADDI: reg_dst = RD_RT;
               OP_LW: begin
                  reg_dst    = RD_RT;
                  mem_to_reg = MTR_MEM;
               end
               default: reg_dst = RD_RD;
            endcase
         end
         S_TRAP: w_next = S_TRAP;
         default: w_next = S_IDLE;
      endcase
   end

   assign illegal_op  = r_illegal;
   assign mem_timeout = r_tmo;
   assign state_o     = r_state;

endmodule
